// File: rtl/long_arith_pkg.sv
// rtl/long_arith_pkg.sv - shared chunk width, FSM states and chunk-count helper
// for the multi-cycle long-word arithmetic blocks.
package long_arith_pkg;

   localparam int ADDER_SIZE = 18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nchunk(input int size);
      return (size + ADDER_SIZE - 1) / ADDER_SIZE;
   endfunction

endpackage

// File: rtl/long_sub_chunk.sv
// rtl/long_sub_chunk.sv - one chunk of subtract-with-borrow; purely combinational,
// reused on every cycle of a long subtraction.
module long_sub_chunk
   import long_arith_pkg::*;
(
   input  logic [ADDER_SIZE-1:0] a,
   input  logic [ADDER_SIZE-1:0] b,
   input  logic                  bin,
   output logic [ADDER_SIZE-1:0] diff,
   output logic                  bout
);

   logic [ADDER_SIZE:0] full;

   // One extra bit catches the wrap: it is set exactly when a < b + bin.
   assign full = {1'b0, a} - {1'b0, b} - {{ADDER_SIZE{1'b0}}, bin};
   assign diff = full[ADDER_SIZE-1:0];
   assign bout = full[ADDER_SIZE];

endmodule

// File: rtl/long_subtractor.sv
// rtl/long_subtractor.sv - SIZE-bit unsigned subtractor, one 18-bit chunk per cycle
// through a single shared chunk cell, with valid/ready on both sides.
module long_subtractor
   import long_arith_pkg::*;
#(
   parameter     FAMILY = "Agilex",
   parameter int SIZE   = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] din_a,
   input  logic [SIZE-1:0] din_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] dout,
   output logic            borrow
);

   localparam int NCHUNK = nchunk(SIZE);
   localparam int XW     = NCHUNK * ADDER_SIZE;
   localparam int KW     = $clog2(NCHUNK);

   if (SIZE <= ADDER_SIZE) begin : g_size_chk
      $error("long_subtractor: SIZE must exceed the chunk width");
   end
   if ((FAMILY != "Agilex") && (FAMILY != "Stratix 10")) begin : g_family_chk
      $error("long_subtractor: unsupported FAMILY");
   end

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic            brw_q, brw_d;
   logic            bout_q, bout_d;
   logic [XW-1:0]   a_q, a_d;
   logic [XW-1:0]   b_q, b_d;
   logic [XW-1:0]   res_q, res_d;

   logic [ADDER_SIZE-1:0] chunk_diff;
   logic                  chunk_bout;

   // Operands shift down one chunk per cycle, so the cell always sees the low chunk.
   long_sub_chunk u_chunk (
      .a    (a_q[ADDER_SIZE-1:0]),
      .b    (b_q[ADDER_SIZE-1:0]),
      .bin  (brw_q),
      .diff (chunk_diff),
      .bout (chunk_bout)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      brw_d   = brw_q;
      bout_d  = bout_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d             = '0;
               a_d[SIZE-1:0]   = din_a;
               b_d             = '0;
               b_d[SIZE-1:0]   = din_b;
               k_d             = '0;
               brw_d           = 1'b0;
               state_d         = RUN;
            end
         end
         RUN: begin
            res_d[k_q*ADDER_SIZE +: ADDER_SIZE] = chunk_diff;
            brw_d = chunk_bout;
            a_d   = a_q >> ADDER_SIZE;
            b_d   = b_q >> ADDER_SIZE;
            if (k_q == KW'(NCHUNK - 1)) begin
               bout_d  = chunk_bout;
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         brw_q   <= 1'b0;
         bout_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         brw_q   <= brw_d;
         bout_q  <= bout_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   // Zero-extension bits of the top chunk are computed but never presented.
   if (XW > SIZE) begin : g_ext
      logic ext_unused;
      assign ext_unused = ^res_q[XW-1:SIZE];
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign dout      = res_q[SIZE-1:0];
   assign borrow    = bout_q;

endmodule

// File: tb/tb_long_subtractor.sv
// tb/tb_long_subtractor.sv - scoreboard bench for long_subtractor at SIZE=1024 and
// SIZE=1000, with directed corner cases and randomized operands.
module tb_long_subtractor;

   typedef logic [1023:0] v_t;

   logic clk;
   int   cyc;
   int   n_checks;
   int   n_fail;
   bit   done_v [2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input bit ok, input string name, input v_t act, input v_t req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (low 480 bits)", name, act[479:0], req[479:0]);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : h
      localparam int SZ  = (g == 0) ? 1024 : 1000;
      localparam int LAT = (g == 0) ? 57 : 56;

      typedef struct {
         logic [SZ-1:0] d;
         logic          br;
         int            acc;
      } exp_t;

      logic          rst_n, in_valid, in_ready, out_valid, out_ready, borrow;
      logic [SZ-1:0] din_a, din_b, dout;
      exp_t          q[$];
      bit            ov_prev, idle_chk;

      long_subtractor #(
         .FAMILY ((g == 0) ? "Agilex" : "Stratix 10"),
         .SIZE   (SZ)
      ) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .din_a     (din_a),
         .din_b     (din_b),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .dout      (dout),
         .borrow    (borrow)
      );

      function automatic logic [SZ-1:0] rnd();
         logic [SZ-1:0] t;
         for (int i = 0; i < SZ; i++) t[i] = 1'($urandom);
         return t;
      endfunction

      // Reference: plain modular subtraction and magnitude compare.
      task automatic send(input logic [SZ-1:0] a, input logic [SZ-1:0] b);
         exp_t e;
         int   n;
         @(posedge clk); #1;
         din_a    = a;
         din_b    = b;
         in_valid = 1'b1;
         n = 0;
         @(negedge clk);
         while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
         end
         if (!in_ready) begin
            check(1'b0, "accept_timeout", v_t'(n), v_t'(300));
            in_valid = 1'b0;
            return;
         end
         e.d   = a - b;
         e.br  = (a < b);
         e.acc = cyc + 1;
         q.push_back(e);
         @(posedge clk); #1;
         in_valid = 1'b0;
         din_a    = rnd();
         din_b    = rnd();
      endtask

      task automatic drain(input bit bp);
         int n;
         n = 0;
         while (q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
         end
         out_ready = 1'b1;
         check(q.size() == 0, "drain_timeout", v_t'(q.size()), v_t'(0));
      endtask

      initial begin
         ov_prev  = 1'b0;
         idle_chk = 1'b0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               ov_prev  = 1'b0;
               idle_chk = 1'b0;
            end else begin
               if (idle_chk) begin
                  check(in_ready && !out_valid, "return_idle", v_t'({in_ready, out_valid}), v_t'(2'b10));
                  idle_chk = 1'b0;
               end
               if (out_valid) begin
                  if (q.size() == 0) begin
                     check(1'b0, "spurious_out_valid", v_t'(out_valid), v_t'(0));
                  end else begin
                     if (!ov_prev)
                        check((cyc - q[0].acc) == LAT, "latency", v_t'(cyc - q[0].acc), v_t'(LAT));
                     check(dout == q[0].d, "dout", v_t'(dout), v_t'(q[0].d));
                     check(borrow == q[0].br, "borrow", v_t'(borrow), v_t'(q[0].br));
                     check(!in_ready, "in_ready_busy", v_t'(in_ready), v_t'(0));
                     if (out_ready) begin
                        void'(q.pop_front());
                        idle_chk = 1'b1;
                     end
                  end
               end
               ov_prev = out_valid && !out_ready;
            end
         end
      end

      initial begin
         logic [SZ-1:0] r, a, b;
         bit            saw;
         int            n;
         rst_n     = 1'b0;
         in_valid  = 1'b0;
         out_ready = 1'b1;
         din_a     = '0;
         din_b     = '0;
         @(negedge clk);
         check(in_ready && !out_valid, "reset_hs", v_t'({in_ready, out_valid}), v_t'(2'b10));
         check(dout == '0 && !borrow, "reset_data", v_t'({dout, borrow}), v_t'(0));
         @(posedge clk); #1;
         rst_n = 1'b1;

         send(SZ'(5), SZ'(3));        drain(1'b0);
         send('0, SZ'(1));            drain(1'b0);
         r = rnd();
         send(r, r);                  drain(1'b0);
         send(SZ'(1) << 18, SZ'(1));  drain(1'b0);

         // Consumer stalls 10 cycles while the input side toggles.
         out_ready = 1'b0;
         send(rnd(), rnd());
         n = 0;
         while (!out_valid && n < LAT + 10) begin
            @(negedge clk);
            n++;
         end
         check(out_valid == 1'b1, "hold_reach_done", v_t'(out_valid), v_t'(1));
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom);
            din_a    = rnd();
            din_b    = rnd();
         end
         @(posedge clk); #1;
         in_valid  = 1'b0;
         out_ready = 1'b1;
         drain(1'b0);

         // Abort while chunk 20 is in flight.
         send(rnd(), rnd());
         repeat (19) @(posedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         check(in_ready && !out_valid, "abort_hs", v_t'({in_ready, out_valid}), v_t'(2'b10));
         check(dout == '0 && !borrow, "abort_data", v_t'({dout, borrow}), v_t'(0));
         q.delete();
         repeat (2) @(posedge clk);
         #1;
         rst_n = 1'b1;
         saw = 1'b0;
         for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            saw |= out_valid;
         end
         check(!saw, "abort_no_result", v_t'(saw), v_t'(0));
         send(SZ'(7), SZ'(9));        drain(1'b0);

         for (int i = 0; i < 8; i++) begin
            a = rnd();
            b = (i % 3 == 0) ? a + SZ'($urandom_range(1, 100)) : rnd();
            send(a, b);
            drain(1'b1);
         end
         done_v[g] = 1'b1;
      end
   end

   initial begin
      wait (done_v[0] && done_v[1]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d required completion", cyc);
      $fatal(1, "bench timeout");
   end

endmodule
